// File: rtl/display_mux_n.sv
// N-digit multiplexed seven-segment driver with internal refresh/blink timing,
// per-digit blank/blink/dp masks, hex decode and a per-frame input snapshot.
module display_mux_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    blink_phase
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        refresh_cnt_q, refresh_cnt_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_blink, src_dp, src_blank;
  logic [3:0]              nib;
  logic                    dark, dp_on;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Blink timebase is free-running so the phase stays continuous across enable gaps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLK_MAX) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    idx_d         = idx_q;
    sh_digits_d   = sh_digits_q;
    sh_blink_d    = sh_blink_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    seg_d         = seg_q;
    an_d          = an_q;
    frame_start_d = 1'b0;
    src_digits    = sh_digits_q;
    src_blink     = sh_blink_q;
    src_dp        = sh_dp_q;
    src_blank     = sh_blank_q;
    nib           = '0;
    dark          = 1'b1;
    dp_on         = 1'b0;

    if (!en) begin
      // Park one cycle before a tick so the first enabled edge starts a fresh frame.
      refresh_cnt_d = CNT_MAX;
      idx_d         = IDX_LAST;
      seg_d         = 8'hFF;
      an_d          = '1;
    end else if (refresh_cnt_q != CNT_MAX) begin
      refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    end else begin
      refresh_cnt_d = '0;
      idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (idx_d == '0) begin
        sh_digits_d   = digits_in;
        sh_blink_d    = blink_mask;
        sh_dp_d       = dp_mask;
        sh_blank_d    = blank_mask;
        src_digits    = digits_in;
        src_blink     = blink_mask;
        src_dp        = dp_mask;
        src_blank     = blank_mask;
        frame_start_d = 1'b1;
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (IDX_W'(k) == idx_d) begin
          nib   = src_digits[4*k +: 4];
          dark  = src_blank[k] | (src_blink[k] & blink_phase_q);
          dp_on = src_dp[k];
        end
      end
      seg_d = dark ? 8'hFF : {~dp_on, hex7(nib)};
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idx_q         <= IDX_LAST;
      sh_digits_q   <= '0;
      sh_blink_q    <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      seg_q         <= 8'hFF;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      sh_digits_q   <= sh_digits_d;
      sh_blink_q    <= sh_blink_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_display_mux_n.sv
// Bench for display_mux_n: a 4-digit instance checked every cycle against a
// slot/frame arithmetic model, plus literal checks and a 1-digit corner instance.
module tb_display_mux_n;
  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0] blink_m = '0, dp_m = '0, blank_m = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic fs, ph;

  logic en1 = 1'b0;
  logic [3:0] dig1 = '0;
  logic blink1 = 1'b0, dp1 = 1'b0, blank1 = 1'b0;
  logic [7:0] seg1;
  logic an1, fs1, ph1;

  display_mux_n #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits), .blink_mask(blink_m),
    .dp_mask(dp_m), .blank_mask(blank_m), .seg(seg), .an(an), .frame_start(fs),
    .blink_phase(ph));

  display_mux_n #(.NUM_DIGITS(1), .REFRESH_DIV(R), .BLINK_DIV(B)) u_one (
    .clk(clk), .rst_n(rst_n), .en(en1), .digits_in(dig1), .blink_mask(blink1),
    .dp_mask(dp1), .blank_mask(blank1), .seg(seg1), .an(an1), .frame_start(fs1),
    .blink_phase(ph1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input logic [3:0] d, input logic bk,
                                           input logic bl, input logic dp, input int phase);
    if (bk || (bl && phase == 1)) return 8'hFF;
    return {~dp, HEX[d]};
  endfunction

  // Model: m_k counts enabled edges of the scan; every R-th one loads slot (m_k/R-1)%N.
  logic [3:0] sh_d [N];
  logic [N-1:0] sh_bl, sh_dp, sh_bk;
  logic [7:0] exp_seg = 8'hFF;
  logic [3:0] exp_an = 4'hF;
  logic exp_fs = 1'b0, exp_ph = 1'b0;
  int m_k = 0, m_nb = 0, ld_ph, slot;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_k = 0; m_nb = 0;
      exp_seg = 8'hFF; exp_an = 4'hF; exp_fs = 1'b0; exp_ph = 1'b0;
      for (int i = 0; i < N; i++) sh_d[i] = '0;
      sh_bl = '0; sh_dp = '0; sh_bk = '0;
    end else begin
      ld_ph = (m_nb / B) % 2;
      m_nb++;
      exp_ph = ((m_nb / B) % 2) == 1;
      exp_fs = 1'b0;
      if (!en) begin
        m_k = R - 1;
        exp_an = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        m_k++;
        if (m_k % R == 0) begin
          slot = (m_k / R - 1) % N;
          if (slot == 0) begin
            for (int i = 0; i < N; i++) sh_d[i] = digits[4*i +: 4];
            sh_bl = blink_m; sh_dp = dp_m; sh_bk = blank_m;
            exp_fs = 1'b1;
          end
          exp_an = ~(4'b0001 << slot);
          exp_seg = model_seg(sh_d[slot], sh_bk[slot], sh_bl[slot], sh_dp[slot], ld_ph);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model_an", an, exp_an);
    chk("model_seg", seg, exp_seg);
    chk("model_fs", fs, exp_fs);
    chk("model_phase", ph, exp_ph);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 4'hF);
    chk("rst_fs", fs, 1'b0);
    chk("rst_phase", ph, 1'b0);
    chk("rst_an1", an1, 1'b1);

    // Scan 12AF; t = negedges since release.
    rst_n = 1'b1; en = 1'b1; digits = 16'h12AF;
    repeat (4) @(negedge clk);
    chk("scan0_an", an, 4'b1110); chk("scan0_seg", seg, 8'h8E); chk("scan0_fs", fs, 1'b1);
    @(negedge clk);
    chk("scan0_fs_pulse", fs, 1'b0);
    repeat (3) @(negedge clk);
    chk("scan1_an", an, 4'b1101); chk("scan1_seg", seg, 8'h88); chk("ph_t8", ph, 1'b0);
    digits = 16'h0000;
    repeat (4) @(negedge clk);
    chk("snap2_an", an, 4'b1011); chk("snap2_seg", seg, 8'hA4);
    repeat (4) @(negedge clk);
    chk("snap3_an", an, 4'b0111); chk("snap3_seg", seg, 8'hF9); chk("ph_t16", ph, 1'b1);
    repeat (4) @(negedge clk);
    chk("new0_seg", seg, 8'hC0); chk("new0_fs", fs, 1'b1);
    repeat (4) @(negedge clk);
    chk("new1_seg", seg, 8'hC0);

    // Blink on digit 0, dp on digit 1 (t=24).
    digits = 16'h12AF; blink_m = 4'b0001; dp_m = 4'b0010;
    repeat (8) @(negedge clk);
    chk("ph_t32", ph, 1'b0);
    repeat (4) @(negedge clk);
    chk("blk0_ph0_seg", seg, 8'h8E); chk("blk0_fs", fs, 1'b1);
    repeat (4) @(negedge clk);
    chk("dp1_seg", seg, 8'h08);
    repeat (12) @(negedge clk);
    chk("blk0_ph1_seg", seg, 8'hFF); chk("blk0_ph1_an", an, 4'b1110);
    repeat (70) @(negedge clk);

    // Enable gap.
    en = 1'b0;
    @(negedge clk);
    chk("gap_an", an, 4'hF); chk("gap_seg", seg, 8'hFF);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_an", an, 4'b1110); chk("reen_fs", fs, 1'b1);
    repeat (30) @(negedge clk);

    // Async reset while an=1011.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1'b1;
    end
    chk("find_slot2", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF); chk("async_seg", seg, 8'hFF); chk("async_phase", ph, 1'b0);
    @(negedge clk);

    // Single-digit instance.
    rst_n = 1'b1; en1 = 1'b1; blank1 = 1'b1; dig1 = 4'h8; dp1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("one_blank_an", an1, 1'b0); chk("one_blank_seg", seg1, 8'hFF); chk("one_fs_a", fs1, 1'b1);
    repeat (4) @(negedge clk);
    chk("one_blank_seg2", seg1, 8'hFF); chk("one_fs_b", fs1, 1'b1);
    blank1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("one_8dp_seg", seg1, 8'h00); chk("one_8dp_an", an1, 1'b0); chk("one_fs_c", fs1, 1'b1);
    @(negedge clk);
    chk("one_fs_low", fs1, 1'b0); chk("one_hold_seg", seg1, 8'h00);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
